// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 slave with a byte-wide register file.
//
// All SPI pins are oversampled in the clock domain; nothing runs on sclk.
// Frame: 16 bits MSB first, command byte {rw, addr[6:0]} then data byte.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   ss, sclk, mosi    SPI inputs (asynchronous to clock)
//   miso              read data out, 0 whenever not shifting read data
//   host_addr         side-port register index
//   host_rdata        combinational read of reg[host_addr] (0 if out of range)
//   wr_pulse/wr_addr/wr_data   one-cycle strobe for a committed SPI write
//   rd_pulse          one-cycle strobe when read data is loaded for shifting
//   frame_err         one-cycle strobe when ss rises mid-frame
//   busy              high while a frame is in progress
module spi_slave_regs #(
    parameter int unsigned REG_COUNT = 16,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ss,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic [6:0] host_addr,
    output logic [7:0] host_rdata,
    output logic       wr_pulse,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_pulse,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [2:0]  r_ss_sync;
    logic [2:0]  r_sclk_sync;
    logic [1:0]  r_mosi_sync;

    logic [4:0]  r_cnt;
    logic [7:0]  r_cmd_sr;
    logic [7:0]  r_data_sr;
    logic [7:0]  r_rd_sr;
    logic        r_rw;
    logic [6:0]  r_addr;
    logic        r_rd_load;
    logic        r_wr_pend;
    logic        r_drive;
    logic        r_frame_err;
    logic [7:0]  r_regs [REG_COUNT];

    logic        w_ss_fall;
    logic        w_ss_rise;
    logic        w_rise;
    logic        w_fall;
    logic        w_in_frame;
    logic        w_rise_act;
    logic        w_fall_act;
    logic        w_addr_ok;
    logic        w_host_ok;
    logic        w_abort_err;

    // Index 0 is the first sync flop, index 2 the edge-detect flop.
    assign w_ss_fall  = r_ss_sync[2] & ~r_ss_sync[1];
    assign w_ss_rise  = ~r_ss_sync[2] & r_ss_sync[1];
    assign w_rise     = ~r_sclk_sync[2] & r_sclk_sync[1];
    assign w_fall     = r_sclk_sync[2] & ~r_sclk_sync[1];

    // An ss rise in the same cycle as an sclk edge wins; the edge is dropped.
    assign w_in_frame = (r_state == S_CMD) || (r_state == S_DATA);
    assign w_rise_act = w_rise & ~w_ss_rise & w_in_frame;
    assign w_fall_act = w_fall & ~w_ss_rise & (r_state == S_DATA) & r_rw;

    assign w_addr_ok  = 32'(r_addr) < REG_COUNT;
    assign w_host_ok  = 32'(host_addr) < REG_COUNT;

    assign w_abort_err = w_ss_rise && (r_state != S_IDLE) &&
                         (r_cnt != 5'd0) && (r_cnt < 5'd16);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ss_fall) w_state_nxt = S_CMD;
            end
            S_CMD: begin
                if (w_ss_rise) w_state_nxt = S_IDLE;
                else if (w_rise_act && r_cnt == 5'd7) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_ss_rise) w_state_nxt = S_IDLE;
                else if (w_rise_act && r_cnt == 5'd15) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (w_ss_rise) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // Sync flops clear to 0 so that ss held low across reset does not
            // look like a new frame start; the slave re-arms on a real fall.
            r_ss_sync   <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cnt       <= '0;
            r_cmd_sr    <= '0;
            r_data_sr   <= '0;
            r_rd_sr     <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_rd_load   <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_drive     <= 1'b0;
            r_frame_err <= 1'b0;
            r_regs      <= '{default: RESET_VAL};
        end else begin
            r_ss_sync   <= {r_ss_sync[1:0], ss};
            r_sclk_sync <= {r_sclk_sync[1:0], sclk};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
            r_rd_load   <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_frame_err <= w_abort_err;

            if (r_state == S_IDLE && w_ss_fall) begin
                r_cnt   <= '0;
                r_rw    <= 1'b0;
                r_drive <= 1'b0;
            end

            if (w_rise_act) begin
                r_cnt <= r_cnt + 5'd1;
                if (r_state == S_CMD) begin
                    r_cmd_sr <= {r_cmd_sr[6:0], r_mosi_sync[1]};
                    if (r_cnt == 5'd7) begin
                        // Latch from the shift register plus the bit arriving now.
                        r_rw      <= r_cmd_sr[6];
                        r_addr    <= {r_cmd_sr[5:0], r_mosi_sync[1]};
                        r_rd_load <= r_cmd_sr[6];
                    end
                end else begin
                    r_data_sr <= {r_data_sr[6:0], r_mosi_sync[1]};
                    if (r_cnt == 5'd15 && !r_rw) r_wr_pend <= 1'b1;
                end
            end

            if (r_rd_load) begin
                r_rd_sr <= w_addr_ok ? r_regs[r_addr[AW-1:0]] : '0;
            end

            // First fall in DATA exposes bit 7; later falls advance the shifter.
            if (w_fall_act) begin
                if (!r_drive) r_drive <= 1'b1;
                else          r_rd_sr <= {r_rd_sr[6:0], 1'b0};
            end

            if (r_wr_pend && w_addr_ok) begin
                r_regs[r_addr[AW-1:0]] <= r_data_sr;
            end
        end
    end

    assign miso       = (r_state == S_DATA) && r_rw && r_drive && r_rd_sr[7];
    assign host_rdata = w_host_ok ? r_regs[host_addr[AW-1:0]] : '0;
    assign wr_pulse   = r_wr_pend & w_addr_ok;
    assign wr_addr    = r_addr;
    assign wr_data    = r_data_sr;
    assign rd_pulse   = r_rd_load;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: directed SPI frames, host pulses and miso
// streams checked against expectation queues by independent monitors.
module tb_spi_slave_regs;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ss    = 1'b1;
    logic       sclk  = 1'b0;
    logic       mosi  = 1'b0;
    logic       miso;
    logic [6:0] host_addr = '0;
    logic [7:0] host_rdata;
    logic       wr_pulse;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_pulse;
    logic       frame_err;
    logic       busy;

    always #5 clock = ~clock;

    spi_slave_regs #(
        .REG_COUNT (16),
        .RESET_VAL (8'h00)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ss         (ss),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .wr_pulse   (wr_pulse),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_pulse   (rd_pulse),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int         kind;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        int          nbits;
        logic [31:0] bits;
    } mf_t;

    ev_t q_ev[$];
    mf_t q_miso[$];
    int  total = 0;
    int  bad   = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push_ev(input int kind, input logic [6:0] a,
                                    input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        q_ev.push_back(e);
    endfunction

    function automatic void push_miso(input int n, input logic [31:0] b);
        mf_t m;
        m.nbits = n;
        m.bits  = b;
        q_miso.push_back(m);
    endfunction

    function automatic void check_ev(input int kind, input logic [6:0] a,
                                     input logic [7:0] d);
        ev_t e;
        if (q_ev.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected pulse: got kind %0d expected none", kind);
        end else begin
            e = q_ev.pop_front();
            chk("pulse kind", kind, e.kind);
            if (e.kind == K_WR && kind == K_WR) begin
                chk("wr_addr", {25'd0, a}, {25'd0, e.addr});
                chk("wr_data", {24'd0, d}, {24'd0, e.data});
            end
        end
    endfunction

    // Pulse monitor
    always @(negedge clock) begin
        if (wr_pulse === 1'b1)  check_ev(K_WR, wr_addr, wr_data);
        if (rd_pulse === 1'b1)  check_ev(K_RD, 7'd0, 8'd0);
        if (frame_err === 1'b1) check_ev(K_ERR, 7'd0, 8'd0);
    end

    // miso monitor: master samples on every sclk rise, frame judged at ss rise
    logic [31:0] mbits = '0;
    int          mcnt  = 0;
    always @(posedge sclk or posedge ss) begin
        if (ss) begin
            if (q_miso.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected frame: got %0d bits expected none", mcnt);
            end else begin
                mf_t m;
                m = q_miso.pop_front();
                chk("miso bit count", mcnt, m.nbits);
                chk("miso stream", mbits, m.bits);
            end
            mbits = '0;
            mcnt  = 0;
        end else begin
            mbits = {mbits[30:0], miso};
            mcnt++;
        end
    end

    // Optional reset pulse in the low phase of bit number reset_at (1-based).
    task automatic spi_frame(input int nbits, input logic [31:0] word,
                             input int gap, input int reset_at);
        @(posedge clock);
        ss = 1'b0;
        repeat (8) @(posedge clock);
        for (int k = 1; k <= nbits; k++) begin
            mosi = word[nbits - k];
            if (k == reset_at) begin
                repeat (20) @(posedge clock);
                reset = 1'b1;
                @(posedge clock);
                reset = 1'b0;
                @(negedge clock);
                chk("outputs after mid-frame reset",
                    {27'd0, miso, wr_pulse, rd_pulse, frame_err, busy}, 32'd0);
                repeat (29) @(posedge clock);
            end else begin
                repeat (50) @(posedge clock);
            end
            sclk = 1'b1;
            repeat (50) @(posedge clock);
            sclk = 1'b0;
        end
        repeat (8) @(posedge clock);
        ss = 1'b1;
        repeat (gap) @(posedge clock);
    endtask

    task automatic host_chk(input string name, input logic [6:0] a,
                            input logic [7:0] exp);
        host_addr = a;
        @(negedge clock);
        chk(name, {24'd0, host_rdata}, {24'd0, exp});
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("reset outputs",
            {27'd0, miso, wr_pulse, rd_pulse, frame_err, busy}, 32'd0);
        host_chk("reset reg0", 7'd0, 8'h00);
        host_chk("reset reg15", 7'd15, 8'h00);
        @(posedge clock);
        reset = 1'b0;
        repeat (10) @(posedge clock);

        // Write reg5 = AA
        push_ev(K_WR, 7'h05, 8'hAA);
        push_miso(16, 32'h0);
        spi_frame(16, 32'h05AA, 20, 0);
        host_chk("reg5 after write", 7'd5, 8'hAA);

        // Read reg5
        push_ev(K_RD, 7'h05, 8'h00);
        push_miso(16, 32'h00AA);
        spi_frame(16, 32'h8500, 20, 0);

        // Out-of-range write 0x55 (aliases reg5 in the low bits)
        push_miso(16, 32'h0);
        spi_frame(16, 32'h553C, 20, 0);
        host_chk("reg5 after OOR write", 7'd5, 8'hAA);
        host_chk("host OOR read", 7'h55, 8'h00);

        // Out-of-range read
        push_ev(K_RD, 7'h55, 8'h00);
        push_miso(16, 32'h0);
        spi_frame(16, 32'hD500, 20, 0);

        // Abort after 11 bits of a write of 0x11 to reg5
        push_ev(K_ERR, 7'h00, 8'h00);
        push_miso(11, 32'h0);
        spi_frame(11, 32'h0511 >> 5, 20, 0);
        host_chk("reg5 after abort", 7'd5, 8'hAA);

        // Next full frame works
        push_ev(K_WR, 7'h07, 8'h3C);
        push_miso(16, 32'h0);
        spi_frame(16, 32'h073C, 20, 0);
        host_chk("reg7 after write", 7'd7, 8'h3C);

        // Reset during bit 12 of a write to reg3
        push_ev(K_WR, 7'h03, 8'h77);
        push_miso(16, 32'h0);
        spi_frame(16, 32'h0377, 20, 0);
        host_chk("reg3 before reset", 7'd3, 8'h77);
        push_miso(16, 32'h0);
        spi_frame(16, 32'h0399, 20, 12);
        host_chk("reg3 after reset", 7'd3, 8'h00);
        host_chk("reg5 after reset", 7'd5, 8'h00);
        chk("busy idle after reset frame", {31'd0, busy}, 32'd0);

        push_ev(K_WR, 7'h03, 8'h42);
        push_miso(16, 32'h0);
        spi_frame(16, 32'h0342, 20, 0);
        host_chk("reg3 after re-arm", 7'd3, 8'h42);

        // 20-bit overlength write commits once
        push_ev(K_WR, 7'h09, 8'h5A);
        push_miso(20, 32'h0);
        spi_frame(20, 32'h095AF, 20, 0);
        host_chk("reg9 overlength", 7'd9, 8'h5A);

        // Back-to-back frames with 8 cycles of ss high, then read-back
        push_ev(K_WR, 7'h0A, 8'h01);
        push_miso(16, 32'h0);
        spi_frame(16, 32'h0A01, 8, 0);
        push_ev(K_WR, 7'h0B, 8'h02);
        push_miso(16, 32'h0);
        spi_frame(16, 32'h0B02, 8, 0);
        push_ev(K_RD, 7'h0A, 8'h00);
        push_miso(16, 32'h0001);
        spi_frame(16, 32'h8A00, 20, 0);
        host_chk("reg10 b2b", 7'd10, 8'h01);
        host_chk("reg11 b2b", 7'd11, 8'h02);

        repeat (20) @(posedge clock);
        chk("pending pulses", q_ev.size(), 0);
        chk("pending frames", q_miso.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
SPI mode-0 slave with an internal byte-wide register file; it is the far-end consumer of spi_master's ss/sclk/mosi and the producer of its miso. All SPI inputs are oversampled in the system clock domain; no logic runs on sclk. A frame is 16 bits, MSB first: a command byte {rw, addr[6:0]} (rw=1 read, 0 write) followed by a data byte. Host logic sees committed writes as a pulse and can read the file through a side port.

Parameters:
REG_COUNT, 16, number of 8-bit registers; legal range 1..128.
RESET_VAL, 8'h00, value loaded into every register on reset.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
ss  input  1  slave select, active low, asynchronous to clock
sclk  input  1  SPI clock, idle low, asynchronous to clock
mosi  input  1  master-out data
miso  output  1  slave-out data; 0 whenever not driving read data
host_addr  input  7  side-port register index
host_rdata  output  8  combinational read of reg[host_addr]; 8'h00 if host_addr >= REG_COUNT
wr_pulse  output  1  one-cycle strobe: SPI write committed
wr_addr  output  7  register index of committed write (valid with wr_pulse)
wr_data  output  8  data of committed write (valid with wr_pulse)
rd_pulse  output  1  one-cycle strobe: read data loaded for shifting
frame_err  output  1  one-cycle strobe: frame aborted by ss rising early
busy  output  1  high while a frame is in progress (synchronized ss low)

Behaviour:
- Sync: ss, sclk, mosi each pass through 2 flops, plus a third flop on ss and sclk for edge detection. rise = sclk rising edge detected; fall = sclk falling edge detected; mosi sampled from its 2nd flop on rise.
- Timing requirement: sclk high and low phases each >= 4 clock cycles; ss setup/hold to first/last sclk edge >= 4 cycles.
- Reset (synchronous): state IDLE, bit counter 0, shift registers 0, all registers = RESET_VAL; miso, wr_pulse, rd_pulse, frame_err, busy = 0. Reset mid-frame discards the frame without a write or frame_err pulse; the slave re-arms on the next synchronized ss falling edge.
- FSM:
  IDLE: synchronized ss falling edge -> CMD, counter 0, busy=1.
  CMD: on each rise shift mosi into cmd_sr, counter+1. On the 8th rise latch rw/addr. If rw=1: in the following cycle load rd_sr with reg[addr] (8'h00 if addr >= REG_COUNT) and pulse rd_pulse. -> DATA.
  DATA: on each rise shift mosi into data_sr, counter+1. Read frames: miso = rd_sr[7] starting on the fall after the 8th rise; rd_sr shifts left on each subsequent fall. On the 16th rise -> DONE. Write frames: one cycle after that rise, if addr < REG_COUNT, write reg[addr] and pulse wr_pulse with wr_addr/wr_data. Out-of-range writes produce no pulse and change nothing.
  DONE: further sclk edges are ignored; miso = 0.
- End of frame: synchronized ss rising edge in any non-IDLE state -> IDLE, busy=0, miso=0. If counter is 1..15, pulse frame_err in the same cycle; nothing is written. An ss rise with counter 0 or in DONE is clean and produces no pulse.
- miso is 0 in IDLE, CMD, DONE, and throughout write frames.
- Simultaneous ss rise and sclk edge in the same cycle: the ss rise takes priority and the edge is dropped.
- A committed write is visible on host_rdata in the cycle after wr_pulse. A register written and read in back-to-back frames returns the new value.

Test Plan:
- Write: ss low, shift 0x05 then 0xAA at sclk = clock/100 -> exactly one wr_pulse with wr_addr=0x05 and wr_data=0xAA; host_addr=5 then gives host_rdata=0xAA; miso stays 0.
- Read: after the write above, shift 0x85 then 0x00 -> one rd_pulse; master samples miso bits 1,0,1,0,1,0,1,0 (0xAA) on the 8 data rising edges; no wr_pulse.
- Out of range (REG_COUNT=16): write 0x55 with 0x3C -> no wr_pulse and registers unchanged. Read 0xD5 -> miso returns 0x00.
- Abort: raise ss after 11 bits of a write frame -> one frame_err pulse, no wr_pulse, target register unchanged. The next full frame completes normally.
- Reset mid-frame: assert reset for 1 cycle during bit 12 of a write to reg 3 -> reg 3 = RESET_VAL, no frame_err, all outputs 0. The next frame after ss toggles works.
- Overlength and back-to-back: a 20-bit write frame commits once at bit 16 and ignores the extra bits. Two frames separated by 8 cycles of ss high both commit.
